// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline control sequencer.
// pc_sel_e selects the next fetch PC; ctrl_state_e is the sequencer state.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {PC_4 = 2'd0, PC_BR = 2'd1, PC_EXC = 2'd2} pc_sel_e;
  typedef enum logic [1:0] {RUN, IMISS, DWAIT, FLUSH} ctrl_state_e;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: pipeline status inputs and stall/kill/PC-select controls.
// master drives the pipeline status and observes the controls; slave is the sequencer.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  import pipeline_ctrl_pkg::*;
  logic dec_valid;
  logic [4:0] dec_rs1_addr, dec_rs2_addr;
  logic dec_rs1_used, dec_rs2_used;
  logic [4:0] exe_wb_addr;
  logic exe_rf_wen, exe_is_load, exe_br_taken;
  logic if_miss, imem_refill_done;
  logic dmem_req_valid, dmem_req_ready, dmem_resp_valid;
  logic exc_valid;
  logic dec_stall, cmiss_stall, dec_kill, pipeline_kill, if_kill;
  pc_sel_e pc_sel;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
    output exe_wb_addr, exe_rf_wen, exe_is_load, exe_br_taken,
    output if_miss, imem_refill_done, dmem_req_valid, dmem_req_ready, dmem_resp_valid, exc_valid,
    input dec_stall, cmiss_stall, dec_kill, pipeline_kill, if_kill, pc_sel, stall_count
  );
  modport slave (
    input dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
    input exe_wb_addr, exe_rf_wen, exe_is_load, exe_br_taken,
    input if_miss, imem_refill_done, dmem_req_valid, dmem_req_ready, dmem_resp_valid, exc_valid,
    output dec_stall, cmiss_stall, dec_kill, pipeline_kill, if_kill, pc_sel, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// load_use_detect: flags a decode source that needs the load result still in execute.
// Inputs: decode sources and use flags, execute destination/wen/load; output: hazard.
module load_use_detect (
  input  logic       dec_valid,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] wb_addr,
  input  logic       rf_wen,
  input  logic       is_load,
  output logic       hazard
);
  assign hazard = dec_valid && is_load && rf_wen && wb_addr != 5'd0 &&
                  ((rs1_used && rs1_addr == wb_addr) || (rs2_used && rs2_addr == wb_addr));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/kill/PC-select sequencer for the 5-stage core.
// Ports: clk, rst_n (sync, active-low), p (pipeline_ctrl_if.slave) carrying status in, controls and stall_count out.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  pipeline_ctrl_if.slave p
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  ctrl_state_e state;
  logic req_acc;
  logic [FW-1:0] fcnt;
  logic [CNT_W-1:0] cnt;
  logic hazard, run, exc, dm, im, br, stall, cmiss, kill;
  load_use_detect u_lud (
    .dec_valid(p.dec_valid),
    .rs1_addr (p.dec_rs1_addr),
    .rs2_addr (p.dec_rs2_addr),
    .rs1_used (p.dec_rs1_used),
    .rs2_used (p.dec_rs2_used),
    .wb_addr  (p.exe_wb_addr),
    .rf_wen   (p.exe_rf_wen),
    .is_load  (p.exe_is_load),
    .hazard   (hazard)
  );
  // RUN-state priority chain; an immediate memory hit falls through to lower events.
  assign run   = state == RUN;
  assign exc   = run && p.exc_valid;
  assign dm    = run && !exc && p.dmem_req_valid && !(p.dmem_req_ready && p.dmem_resp_valid);
  assign im    = run && !exc && !dm && p.if_miss;
  assign br    = run && !exc && !dm && !im && p.exe_br_taken;
  assign stall = run && !exc && !dm && !im && !br && hazard;
  assign cmiss = dm || im || state == IMISS || state == DWAIT;
  assign kill  = exc || state == FLUSH;
  assign p.dec_stall     = stall;
  assign p.cmiss_stall   = cmiss;
  assign p.dec_kill      = br;
  assign p.pipeline_kill = kill;
  assign p.if_kill       = kill || br;
  assign p.pc_sel        = exc ? PC_EXC : br ? PC_BR : PC_4;
  assign p.stall_count   = cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      req_acc <= 1'b0;
      fcnt    <= '0;
      cnt     <= '0;
    end else begin
      if ((stall || cmiss) && cnt != '1) cnt <= cnt + CNT_W'(1);
      case (state)
        RUN:
          if (exc) begin
            state <= FLUSH;
            fcnt  <= FW'(FLUSH_CYCLES - 1);
          end else if (dm) begin
            state   <= DWAIT;
            req_acc <= p.dmem_req_ready;
          end else if (im) state <= IMISS;
        IMISS: if (p.imem_refill_done) state <= RUN;
        DWAIT: begin
          req_acc <= req_acc || p.dmem_req_ready;
          if (p.dmem_resp_valid && (req_acc || p.dmem_req_ready)) state <= RUN;
        end
        FLUSH: if (fcnt == '0) state <= RUN; else fcnt <= fcnt - FW'(1);
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;
  localparam logic [6:0] IDLE = 7'b00000_00;
  localparam logic [6:0] LU   = 7'b10000_00;
  localparam logic [6:0] CM   = 7'b01000_00;
  localparam logic [6:0] BR   = 7'b00101_01;
  localparam logic [6:0] EXC  = 7'b00011_10;
  localparam logic [6:0] FL   = 7'b00011_00;
  logic clk, rst_n;
  int ncmp, nerr;
  logic [6:0] ctl;
  pipeline_ctrl_if #(.CNT_W(4)) b ();
  pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .p(b));
  assign ctl = {b.dec_stall, b.cmiss_stall, b.dec_kill, b.pipeline_kill, b.if_kill, b.pc_sel};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task idle();
    b.dec_valid = 0; b.dec_rs1_addr = 0; b.dec_rs2_addr = 0; b.dec_rs1_used = 0; b.dec_rs2_used = 0;
    b.exe_wb_addr = 0; b.exe_rf_wen = 0; b.exe_is_load = 0; b.exe_br_taken = 0;
    b.if_miss = 0; b.imem_refill_done = 0; b.dmem_req_valid = 0; b.dmem_req_ready = 0;
    b.dmem_resp_valid = 0; b.exc_valid = 0;
  endtask
  task load_hazard(input logic [4:0] wb, input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    b.dec_valid = 1; b.exe_is_load = 1; b.exe_rf_wen = 1; b.exe_wb_addr = wb;
    b.dec_rs1_addr = r1; b.dec_rs1_used = u1; b.dec_rs2_addr = r2; b.dec_rs2_used = u2;
  endtask
  task test_reset();
    idle(); rst_n = 0;
    @(negedge clk); @(negedge clk); rst_n = 1; #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL reset_ctl got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd0) begin $display("FAIL reset_cnt got %0d want 0", b.stall_count); nerr++; end
  endtask
  task test_load_use();
    @(negedge clk); load_hazard(5'd5, 5'd0, 0, 5'd5, 1); #1;
    ncmp++; if (ctl !== LU) begin $display("FAIL lu_rs2 got %b want %b", ctl, LU); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL lu_release got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd1) begin $display("FAIL lu_cnt1 got %0d want 1", b.stall_count); nerr++; end
    @(negedge clk); load_hazard(5'd0, 5'd0, 0, 5'd0, 1); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL lu_x0 got %b want %b", ctl, IDLE); nerr++; end
    @(negedge clk); load_hazard(5'd7, 5'd7, 0, 5'd3, 1); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL lu_unused got %b want %b", ctl, IDLE); nerr++; end
    @(negedge clk); load_hazard(5'd7, 5'd7, 1, 5'd3, 0); b.exe_is_load = 0; #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL lu_notload got %b want %b", ctl, IDLE); nerr++; end
    @(negedge clk); load_hazard(5'd7, 5'd7, 1, 5'd3, 0); #1;
    ncmp++; if (ctl !== LU) begin $display("FAIL lu_rs1 got %b want %b", ctl, LU); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (b.stall_count !== 4'd2) begin $display("FAIL lu_cnt2 got %0d want 2", b.stall_count); nerr++; end
  endtask
  task test_branch();
    @(negedge clk); b.exe_br_taken = 1; #1;
    ncmp++; if (ctl !== BR) begin $display("FAIL br_taken got %b want %b", ctl, BR); nerr++; end
    @(negedge clk); load_hazard(5'd9, 5'd9, 1, 5'd0, 0); #1;
    ncmp++; if (ctl !== BR) begin $display("FAIL br_over_lu got %b want %b", ctl, BR); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL br_once got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd2) begin $display("FAIL br_cnt got %0d want 2", b.stall_count); nerr++; end
  endtask
  task test_imiss();
    @(negedge clk); b.if_miss = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL im_enter got %b want %b", ctl, CM); nerr++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); b.exe_br_taken = 1; #1;
      ncmp++; if (ctl !== CM) begin $display("FAIL im_wait%0d got %b want %b", i, ctl, CM); nerr++; end
    end
    @(negedge clk); idle(); b.imem_refill_done = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL im_done got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); b.if_miss = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL im_b2b got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); b.imem_refill_done = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL im_b2b_done got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL im_exit got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd9) begin $display("FAIL im_cnt got %0d want 9", b.stall_count); nerr++; end
    @(negedge clk); b.imem_refill_done = 1; #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL im_stray got %b want %b", ctl, IDLE); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL im_stray_after got %b want %b", ctl, IDLE); nerr++; end
  endtask
  task test_dmem();
    @(negedge clk); b.dmem_req_valid = 1; b.dmem_req_ready = 1; b.dmem_resp_valid = 1; #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL dm_hit got %b want %b", ctl, IDLE); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL dm_hit_after got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd9) begin $display("FAIL dm_hit_cnt got %0d want 9", b.stall_count); nerr++; end
    @(negedge clk); b.dmem_req_valid = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL dm_enter got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); b.dmem_resp_valid = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL dm_stray_resp got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); b.dmem_req_ready = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL dm_accept got %b want %b", ctl, CM); nerr++; end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); #1;
      ncmp++; if (ctl !== CM) begin $display("FAIL dm_wait%0d got %b want %b", i, ctl, CM); nerr++; end
    end
    @(negedge clk); b.dmem_resp_valid = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL dm_resp got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL dm_exit got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd15) begin $display("FAIL dm_cnt got %0d want 15", b.stall_count); nerr++; end
  endtask
  task test_exception();
    @(negedge clk); b.exc_valid = 1; b.exe_br_taken = 1; #1;
    ncmp++; if (ctl !== EXC) begin $display("FAIL exc_detect got %b want %b", ctl, EXC); nerr++; end
    @(negedge clk); b.exc_valid = 0; #1;
    ncmp++; if (ctl !== FL) begin $display("FAIL exc_flush1 got %b want %b", ctl, FL); nerr++; end
    @(negedge clk); #1;
    ncmp++; if (ctl !== FL) begin $display("FAIL exc_flush2 got %b want %b", ctl, FL); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL exc_exit got %b want %b", ctl, IDLE); nerr++; end
  endtask
  task test_saturate();
    @(negedge clk); b.if_miss = 1; #1;
    @(negedge clk); idle(); b.imem_refill_done = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL sat_miss got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (b.stall_count !== 4'd15) begin $display("FAIL sat_cnt got %0d want 15", b.stall_count); nerr++; end
  endtask
  task test_reset_dwait();
    @(negedge clk); b.dmem_req_valid = 1; #1;
    ncmp++; if (ctl !== CM) begin $display("FAIL rd_enter got %b want %b", ctl, CM); nerr++; end
    @(negedge clk); idle(); rst_n = 0;
    @(negedge clk); rst_n = 1; b.dmem_resp_valid = 1; #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL rd_run got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd0) begin $display("FAIL rd_cnt got %0d want 0", b.stall_count); nerr++; end
    @(negedge clk); idle(); #1;
    ncmp++; if (ctl !== IDLE) begin $display("FAIL rd_late_resp got %b want %b", ctl, IDLE); nerr++; end
    ncmp++; if (b.stall_count !== 4'd0) begin $display("FAIL rd_cnt_after got %0d want 0", b.stall_count); nerr++; end
  endtask
  initial begin
    ncmp = 0; nerr = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_imiss();
    test_dmem();
    test_exception();
    test_saturate();
    test_reset_dwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
